// File: rtl/edit_pulse_gen.sv
// Edit-mode increment pulse generator for a clock/alarm setting UI.
// An increase press makes one increment strobe. Holding the button then
// auto-repeats: the first repeat comes after REPEAT_DELAY ticks and later
// repeats come every REPEAT_PERIOD ticks. The nextField button cycles
// through the fields of the current view. If the edit target changes while
// the button is held, repeating stops (LOCKOUT) until the button is released.
module edit_pulse_gen #(
  parameter  int NUM_VIEWS     = 2,
  parameter  int NUM_FIELDS    = 2,
  parameter  int REPEAT_DELAY  = 500,
  parameter  int REPEAT_PERIOD = 100,
  localparam int VIEW_W  = (NUM_VIEWS  > 1) ? $clog2(NUM_VIEWS)  : 1,
  localparam int FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD,
  localparam int CNT_W   = $clog2(MAX_CNT + 1),
  localparam int NPULSE  = NUM_VIEWS * NUM_FIELDS
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               tick,
  input  logic               editMode,
  input  logic [VIEW_W-1:0]  viewSel,
  input  logic               increase,
  input  logic               nextField,
  output logic [NPULSE-1:0]  incPulse,
  output logic [FIELD_W-1:0] selected,
  output logic               repeating
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKOUT} state_t;

  state_t              state, nextState;
  logic [CNT_W-1:0]    cnt, nextCnt;
  logic                prevInc, prevNext;
  logic [VIEW_W-1:0]   prevView;
  logic                incPress, nextPress, selAdvance, fire;
  logic [NPULSE-1:0]   pulseBits;

  assign incPress   = increase  & ~prevInc;
  assign nextPress  = nextField & ~prevNext;
  assign selAdvance = editMode  & nextPress;

  // Register the FSM state and the repeat counter.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state and pulse-event logic. Release has highest priority, so an
  // expiring tick in the same cycle as a release makes no pulse. A target
  // change (view switch or edit mode dropping) also kills the pulse. A field
  // advance in the same cycle as a pulse lets the pulse through on the old
  // field, and then the FSM enters lockout.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (editMode && incPress) begin
          fire      = 1'b1;
          nextCnt   = CNT_W'(REPEAT_DELAY);
          nextState = selAdvance ? LOCKOUT : DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!increase) begin
          nextState = IDLE;
        end else if (!editMode || (viewSel != prevView)) begin
          nextState = LOCKOUT;
        end else if (tick && (cnt == CNT_W'(1))) begin
          fire      = 1'b1;
          nextCnt   = CNT_W'(REPEAT_PERIOD);
          nextState = selAdvance ? LOCKOUT : REPEAT;
        end else if (selAdvance) begin
          nextState = LOCKOUT;
        end else if (tick) begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      LOCKOUT: begin
        if (!increase) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Decode the pulse event to the one-hot {view, field} strobe. A viewSel
  // with no matching view decodes to nothing, but the FSM still runs.
  for (genvar v = 0; v < NUM_VIEWS; v++) begin : gView
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : gField
      assign pulseBits[v*NUM_FIELDS+f] = fire && (viewSel == VIEW_W'(v)) &&
                                         (selected == FIELD_W'(f));
    end
  end

  // Register the edge-detect history, the outputs and the field selection.
  // The history loads 1 in reset, so a button held through reset does not
  // count as a press. The pulse is masked by its previous value: when
  // REPEAT_DELAY or REPEAT_PERIOD is 1 with back-to-back ticks, a strobe
  // bit must not stay high for two cycles in a row.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      prevInc   <= 1'b1;
      prevNext  <= 1'b1;
      prevView  <= '0;
      incPulse  <= '0;
      selected  <= '0;
      repeating <= 1'b0;
    end else begin
      prevInc   <= increase;
      prevNext  <= nextField;
      prevView  <= viewSel;
      incPulse  <= pulseBits & ~incPulse;
      repeating <= (nextState == REPEAT);
      if (!editMode)
        selected <= '0;
      else if (nextPress)
        selected <= (selected == FIELD_W'(NUM_FIELDS - 1)) ? '0 : selected + FIELD_W'(1);
    end
  end

endmodule

// File: tb/tb_edit_pulse_gen.sv
// Directed bench for edit_pulse_gen: 2 views, 2 fields, delay 3, period 2.
module tb_edit_pulse_gen;

  logic       clk = 1'b0;
  logic       resetN, tick, editMode, increase, nextField;
  logic [0:0] viewSel;
  logic [3:0] incPulse;
  logic [0:0] selected;
  logic       repeating;

  int checks = 0;
  int errors = 0;

  edit_pulse_gen #(
    .NUM_VIEWS(2), .NUM_FIELDS(2), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .resetN(resetN), .tick(tick), .editMode(editMode),
    .viewSel(viewSel), .increase(increase), .nextField(nextField),
    .incPulse(incPulse), .selected(selected), .repeating(repeating)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, tk, em, vs, inc, nf;
    logic [3:0] p;
    logic       s, r;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, tk, em, vs, inc, nf,
                     input logic [3:0] p, input logic s, r);
    vec_t v;
    v.rst = rst; v.tk = tk; v.em = em; v.vs = vs; v.inc = inc; v.nf = nf;
    v.p = p; v.s = s; v.r = r;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, tk, em, vs, inc, nf);
    resetN = rst; tick = tk; editMode = em; viewSel = vs; increase = inc; nextField = nf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] p, input logic s, r);
    checks++;
    if (incPulse !== p) begin
      errors++;
      $display("FAIL %s incPulse got %b want %b", name, incPulse, p);
    end
    checks++;
    if (selected !== s) begin
      errors++;
      $display("FAIL %s selected got %b want %b", name, selected, s);
    end
    checks++;
    if (repeating !== r) begin
      errors++;
      $display("FAIL %s repeating got %b want %b", name, repeating, r);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    //   rst tk em vs inc nf   pulse sel rep
    add(0, 0, 0, 0, 0, 0,  4'h0, 0, 0);  // reset
    add(0, 1, 1, 1, 1, 0,  4'h0, 0, 0);  // button held through reset
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);  // still held: not a press
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    // hold for 10 cycles: pulses on cycles 1,4,6,8,10 after the press
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 1);
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 1);
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);  // release
    // nextField stepping with wrap
    add(1, 1, 1, 1, 0, 1,  4'h0, 1, 0);
    add(1, 1, 1, 1, 0, 0,  4'h0, 1, 0);
    add(1, 1, 1, 1, 0, 1,  4'h0, 0, 0);
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 0, 1,  4'h0, 1, 0);
    add(1, 1, 1, 1, 0, 1,  4'h0, 1, 0);  // held: no second step
    add(1, 1, 1, 1, 0, 0,  4'h0, 1, 0);
    // edit mode off clears selection and blocks pulses
    add(1, 1, 0, 1, 0, 0,  4'h0, 0, 0);
    add(1, 1, 0, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);  // edit on with button already held
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    // view switch in DELAY leads to lockout
    add(1, 1, 1, 0, 1, 0,  4'h1, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 0);  // re-press: bit 2
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    // release in the same cycle as an expiring tick
    add(1, 1, 1, 1, 1, 0,  4'h4, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 1, 0,  4'h0, 0, 0);
    add(1, 1, 1, 1, 0, 0,  4'h0, 0, 0);
    // simultaneous increase + nextField: pulse on old field, then lockout
    add(1, 1, 1, 0, 1, 1,  4'h1, 1, 0);
    add(1, 1, 1, 0, 1, 0,  4'h0, 1, 0);
    add(1, 1, 1, 0, 1, 0,  4'h0, 1, 0);
    add(1, 1, 1, 0, 1, 0,  4'h0, 1, 0);
    add(1, 1, 1, 0, 0, 0,  4'h0, 1, 0);
    add(1, 1, 1, 0, 1, 0,  4'h2, 1, 0);
    add(1, 1, 1, 0, 0, 0,  4'h0, 1, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].tk, vq[i].em, vq[i].vs, vq[i].inc, vq[i].nf);
      step();
      check($sformatf("vec%0d", i), vq[i].p, vq[i].s, vq[i].r);
    end

    // Reset during REPEAT with the button held
    drive(1, 1, 0, 0, 0, 0); step(); check("rstA_clr", 4'h0, 0, 0);
    drive(1, 1, 1, 0, 0, 0); step(); check("rstA_idle", 4'h0, 0, 0);
    drive(1, 1, 1, 0, 1, 0); step(); check("rstA_p0", 4'h1, 0, 0);
    step(); check("rstA_d1", 4'h0, 0, 0);
    step(); check("rstA_d2", 4'h0, 0, 0);
    step(); check("rstA_p1", 4'h1, 0, 1);
    step(); check("rstA_r1", 4'h0, 0, 1);
    drive(0, 1, 1, 0, 1, 0); step(); check("rstA_rst", 4'h0, 0, 0);
    drive(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(); check($sformatf("rstA_hold%0d", i), 4'h0, 0, 0);
    end
    drive(1, 1, 1, 0, 0, 0); step(); check("rstA_rel", 4'h0, 0, 0);
    drive(1, 1, 1, 0, 1, 0); step(); check("rstA_repress", 4'h1, 0, 0);
    drive(1, 1, 1, 0, 0, 0); step(); check("rstA_end", 4'h0, 0, 0);

    // Sparse ticks (every 4th cycle): first repeat lands exactly on the 3rd tick
    drive(1, 0, 1, 0, 1, 0); step(); check("tickB_p0", 4'h1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, (i % 4 == 3), 1, 0, 1, 0);
      step();
      check($sformatf("tickB_c%0d", i), (i == 11) ? 4'h1 : 4'h0, 0, (i >= 11));
    end
    drive(1, 0, 1, 0, 0, 0); step(); check("tickB_rel", 4'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
